// File: rtl/mem_bus_stage_pkg.sv
// Shared definitions for the MEM-stage bus block: aluop codes, FSM states and
// helpers that decode memory ops into byte lanes, store data and alignment.
// Purely declarative; no ports.
package mem_bus_stage_pkg;

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic [7:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lo[0];
      OP_LW, OP_SW:         return (lo != 2'b00);
      default:              return 1'b0;
    endcase
  endfunction

  // Big-endian lanes: byte address 0 lives in bits 31:24, so sel bit 3.
  function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] lo);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b1000 >> lo;
      OP_LH, OP_LHU, OP_SH: return lo[1] ? 4'b0011 : 4'b1100;
      OP_LW, OP_SW:         return 4'b1111;
      default:              return 4'b0000;
    endcase
  endfunction

  // Replicating the data lets the slave pick it up from whichever lane sel enables.
  function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   return {4{d[7:0]}};
      OP_SH:   return {2{d[15:0]}};
      OP_SW:   return d;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_stage_load_align.sv
// load_align: picks the addressed big-endian byte/half out of a read word and
// sign- or zero-extends it according to the load op. Combinational.
// Ports: i_aluop (load op), i_addr_lo (addr[1:0]), i_rdata (bus word), o_data (GPR value).
module load_align
  import mem_bus_stage_pkg::*;
(
  input  logic [7:0]  i_aluop,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[31:24];
    case (i_addr_lo)
      2'b01:   w_byte = i_rdata[23:16];
      2'b10:   w_byte = i_rdata[15:8];
      2'b11:   w_byte = i_rdata[7:0];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];

    o_data = 32'h0;
    case (i_aluop)
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'h0, w_byte};
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'h0, w_half};
      OP_LW:   o_data = i_rdata;
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_bus_stage.sv
// mem_bus_stage: MEM pipeline stage; passes ALU results through and runs
// loads/stores over a req/ack bus via an IDLE->BUSY->DONE FSM (>=3 cycles/access).
// Backpressure: stallreq_o holds the pipeline in IDLE/BUSY; the bus may hold ack off forever.
// Ports: EX/MEM inputs (wd/wreg/wdata/hi/lo/whilo, aluop, mem_addr, reg2), bus master
// (bus_*), MEM/WB outputs (wd/wreg/wdata/hi/lo/whilo), stallreq_o, align_err_o.
module mem_bus_stage
  import mem_bus_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq_o,
  output logic        align_err_o
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [3:0]  r_sel;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [7:0]  r_aluop;
  logic [1:0]  r_addr_lo;

  logic        w_is_mem;
  logic        w_misalign;
  logic        w_start;
  logic [31:0] w_load_data;

  assign w_is_mem   = is_mem_op(aluop_i);
  assign w_misalign = is_misaligned(aluop_i, mem_addr_i[1:0]);
  assign w_start    = (r_state == ST_IDLE) && w_is_mem && !w_misalign;

  // Bus request fields are latched on entry to BUSY so they stay stable until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= 32'h0;
      r_sel     <= 4'h0;
      r_we      <= 1'b0;
      r_wdata   <= 32'h0;
      r_rdata   <= 32'h0;
      r_aluop   <= 8'h0;
      r_addr_lo <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_addr    <= {mem_addr_i[31:2], 2'b00};
        r_sel     <= lane_sel(aluop_i, mem_addr_i[1:0]);
        r_we      <= is_store_op(aluop_i);
        r_wdata   <= store_data(aluop_i, reg2_i);
        r_aluop   <= aluop_i;
        r_addr_lo <= mem_addr_i[1:0];
      end
      if ((r_state == ST_BUSY) && bus_ack_i) begin
        r_rdata <= bus_rdata_i;
      end
    end
  end

  load_align u_load_align (
    .i_aluop   (r_aluop),
    .i_addr_lo (r_addr_lo),
    .i_rdata   (r_rdata),
    .o_data    (w_load_data)
  );

  assign bus_req_o   = (r_state == ST_BUSY);
  assign bus_we_o    = (r_state == ST_BUSY) && r_we;
  assign bus_addr_o  = r_addr;
  assign bus_sel_o   = r_sel;
  assign bus_wdata_o = r_wdata;

  always_comb begin
    w_state_nxt = r_state;
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    hi_o        = hi_i;
    lo_o        = lo_i;
    whilo_o     = whilo_i;
    stallreq_o  = 1'b0;
    align_err_o = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A memory op never writes back until DONE; a misaligned one never does.
        if (w_is_mem) begin
          wreg_o = 1'b0;
          if (w_misalign) begin
            align_err_o = 1'b1;
          end else begin
            stallreq_o  = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        wreg_o     = 1'b0;
        stallreq_o = 1'b1;
        if (bus_ack_i) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (r_we) wreg_o = 1'b0;
        else      wdata_o = w_load_data;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (rst) begin
      wd_o        = 5'h0;
      wreg_o      = 1'b0;
      wdata_o     = 32'h0;
      hi_o        = 32'h0;
      lo_o        = 32'h0;
      whilo_o     = 1'b0;
      stallreq_o  = 1'b0;
      align_err_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_bus_stage.sv
module tb_mem_bus_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i, hi_i, lo_i;
  logic        whilo_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o, bus_rdata_i;
  logic        bus_ack_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic        whilo_o, stallreq_o, align_err_o;

  always #5 clk = ~clk;

  mem_bus_stage dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
    .stallreq_o(stallreq_o), .align_err_o(align_err_o)
  );

  typedef struct {
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic        align;
    int          stall;
    int          busy;
    logic [31:0] baddr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] bwdata;
    logic [4:0]  wd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic wreg, input logic [31:0] wdata, input logic chk_wdata,
                              input logic align, input int stall, input int busy,
                              input logic [31:0] baddr, input logic [3:0] sel, input logic we,
                              input logic [31:0] bwdata);
    exp_t e;
    e.wreg = wreg; e.wdata = wdata; e.chk_wdata = chk_wdata; e.align = align;
    e.stall = stall; e.busy = busy; e.baddr = baddr; e.sel = sel; e.we = we; e.bwdata = bwdata;
    e.wd = 5'h0; e.hi = 32'h0; e.lo = 32'h0; e.whilo = 1'b0;
    return e;
  endfunction

  // Drive one op at a negedge, service the bus, and score the result when the stall drops.
  task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [31:0] rdata, input int ack_at,
                        input logic [4:0] wd, input logic [31:0] wdat, input exp_t e_in);
    exp_t e, got;
    int   stall_cnt, busy_cnt, cyc;
    bit   done;
    e = e_in;
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = wd; wreg_i = 1'b1; wdata_i = wdat;
    hi_i = $urandom; lo_i = $urandom; whilo_i = 1'($urandom_range(0, 1));
    e.wd = wd; e.hi = hi_i; e.lo = lo_i; e.whilo = whilo_i;
    sb_q.push_back(e);
    got = e;
    stall_cnt = 0; busy_cnt = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 64) begin
      #1;
      bus_ack_i = 1'b0;
      if (bus_req_o) begin
        busy_cnt++;
        chk({name, ".bus_addr"}, bus_addr_o, e.baddr);
        chk({name, ".bus_sel"}, 32'(bus_sel_o), 32'(e.sel));
        chk({name, ".bus_we"}, 32'(bus_we_o), 32'(e.we));
        if (e.we) chk({name, ".bus_wdata"}, bus_wdata_o, e.bwdata);
        if (busy_cnt == ack_at) begin
          bus_ack_i = 1'b1;
          bus_rdata_i = rdata;
        end
      end
      if (stallreq_o) begin
        stall_cnt++;
      end else begin
        got = sb_q.pop_front();
        chk({name, ".wd"}, 32'(wd_o), 32'(got.wd));
        chk({name, ".wreg"}, 32'(wreg_o), 32'(got.wreg));
        if (got.chk_wdata) chk({name, ".wdata"}, wdata_o, got.wdata);
        chk({name, ".align_err"}, 32'(align_err_o), 32'(got.align));
        chk({name, ".hi"}, hi_o, got.hi);
        chk({name, ".lo"}, lo_o, got.lo);
        chk({name, ".whilo"}, 32'(whilo_o), 32'(got.whilo));
        chk({name, ".stall_cycles"}, 32'(stall_cnt), 32'(got.stall));
        chk({name, ".busy_cycles"}, 32'(busy_cnt), 32'(got.busy));
        chk({name, ".bus_req_at_end"}, 32'(bus_req_o), 32'h0);
        done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus_ack_i = 1'b0;
    chk({name, ".completed"}, 32'(done), 32'h1);
    if (!done && sb_q.size() > 0) got = sb_q.pop_front();
  endtask

  logic [7:0] nonmem_ops [7];

  initial begin
    nonmem_ops = '{8'h00, 8'h21, 8'h25, 8'hE2, 8'hE6, 8'hEA, 8'hFF};
    rst = 1'b1; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    wd_i = 5'h1F; wreg_i = 1'b1; wdata_i = 32'hFFFF_FFFF; hi_i = 32'h1111_2222; lo_i = 32'h3333_4444;
    whilo_i = 1'b1; aluop_i = 8'hE3; mem_addr_i = 32'h0000_0010; reg2_i = 32'h5555_6666;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.wd", 32'(wd_o), 32'h0);
    chk("rst.wreg", 32'(wreg_o), 32'h0);
    chk("rst.wdata", wdata_o, 32'h0);
    chk("rst.hi", hi_o, 32'h0);
    chk("rst.lo", lo_o, 32'h0);
    chk("rst.whilo", 32'(whilo_o), 32'h0);
    chk("rst.stall", 32'(stallreq_o), 32'h0);
    chk("rst.bus_req", 32'(bus_req_o), 32'h0);
    chk("rst.bus_addr", bus_addr_o, 32'h0);
    chk("rst.bus_sel", 32'(bus_sel_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    //     name        op      addr          reg2          rdata         ack wd     wdata_i
    run_op("nop",      8'h21,  32'h0000_0000, 32'h0,        32'h0,        0,  5'd5,  32'h1234,
           mk(1, 32'h1234, 1, 0, 0, 0, 32'h0, 4'h0, 0, 32'h0));
    run_op("lb_1003",  8'hE0,  32'h0000_1003, 32'h0,        32'h0000_00F0, 1, 5'd7,  32'h0,
           mk(1, 32'hFFFF_FFF0, 1, 0, 2, 1, 32'h0000_1000, 4'b0001, 0, 32'h0));
    run_op("sh_2002",  8'hE9,  32'h0000_2002, 32'hAAAA_BEEF, 32'h0,       3,  5'd9,  32'h0,
           mk(0, 32'h0, 0, 0, 4, 3, 32'h0000_2000, 4'b0011, 1, 32'hBEEF_BEEF));
    run_op("lw_mis",   8'hE3,  32'h0000_0006, 32'h0,        32'h0,        1,  5'd3,  32'h0,
           mk(0, 32'h0, 0, 1, 0, 0, 32'h0, 4'h0, 0, 32'h0));
    run_op("lhu_0",    8'hE5,  32'h0000_0000, 32'h0,        32'h8001_5A5A, 1, 5'd4,  32'h0,
           mk(1, 32'h0000_8001, 1, 0, 2, 1, 32'h0, 4'b1100, 0, 32'h0));
    run_op("lh_0",     8'hE1,  32'h0000_0000, 32'h0,        32'h8001_5A5A, 1, 5'd6,  32'h0,
           mk(1, 32'hFFFF_8001, 1, 0, 2, 1, 32'h0, 4'b1100, 0, 32'h0));
    run_op("lbu_1001", 8'hE4,  32'h0000_1001, 32'h0,        32'h1234_5678, 2, 5'd8,  32'h0,
           mk(1, 32'h0000_0034, 1, 0, 3, 2, 32'h0000_1000, 4'b0100, 0, 32'h0));
    run_op("lb_1000",  8'hE0,  32'h0000_1000, 32'h0,        32'h80AB_CDEF, 1, 5'd10, 32'h0,
           mk(1, 32'hFFFF_FF80, 1, 0, 2, 1, 32'h0000_1000, 4'b1000, 0, 32'h0));
    run_op("sb_3001",  8'hE8,  32'h0000_3001, 32'h0000_00A5, 32'h0,       2,  5'd11, 32'h0,
           mk(0, 32'h0, 0, 0, 3, 2, 32'h0000_3000, 4'b0100, 1, 32'hA5A5_A5A5));
    run_op("sw_4000",  8'hEB,  32'h0000_4000, 32'hDEAD_BEEF, 32'h0,       1,  5'd12, 32'h0,
           mk(0, 32'h0, 0, 0, 2, 1, 32'h0000_4000, 4'b1111, 1, 32'hDEAD_BEEF));
    run_op("lw_8",     8'hE3,  32'h0000_0008, 32'h0,        32'hCAFE_F00D, 1, 5'd13, 32'h0,
           mk(1, 32'hCAFE_F00D, 1, 0, 2, 1, 32'h0000_0008, 4'b1111, 0, 32'h0));
    run_op("lhu_2",    8'hE5,  32'h0000_0002, 32'h0,        32'h1234_ABCD, 1, 5'd14, 32'h0,
           mk(1, 32'h0000_ABCD, 1, 0, 2, 1, 32'h0, 4'b0011, 0, 32'h0));
    run_op("sh_mis",   8'hE9,  32'h0000_2001, 32'h1111_2222, 32'h0,       1,  5'd15, 32'h0,
           mk(0, 32'h0, 0, 1, 0, 0, 32'h0, 4'h0, 0, 32'h0));
    run_op("lh_mis",   8'hE1,  32'h0000_0003, 32'h0,        32'h0,        1,  5'd16, 32'h0,
           mk(0, 32'h0, 0, 1, 0, 0, 32'h0, 4'h0, 0, 32'h0));
    run_op("sw_mis",   8'hEB,  32'h0000_0002, 32'h0,        32'h0,        1,  5'd17, 32'h0,
           mk(0, 32'h0, 0, 1, 0, 0, 32'h0, 4'h0, 0, 32'h0));

    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      d = $urandom;
      run_op("nonmem", nonmem_ops[$urandom_range(0, 6)], $urandom, $urandom, 32'h0, 0,
             5'($urandom), d, mk(1, d, 1, 0, 0, 0, 32'h0, 4'h0, 0, 32'h0));
    end

    // Reset while a load is waiting for ack.
    aluop_i = 8'hE3; mem_addr_i = 32'h0000_0040; wd_i = 5'd2; wreg_i = 1'b1;
    @(negedge clk);
    #1;
    chk("rstbusy.in_busy", 32'(bus_req_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("rstbusy.stall_during_rst", 32'(stallreq_o), 32'h0);
    chk("rstbusy.wd_during_rst", 32'(wd_o), 32'h0);
    @(negedge clk);
    #1;
    chk("rstbusy.bus_req", 32'(bus_req_o), 32'h0);
    chk("rstbusy.bus_addr", bus_addr_o, 32'h0);
    chk("rstbusy.bus_sel", 32'(bus_sel_o), 32'h0);
    chk("rstbusy.bus_we", 32'(bus_we_o), 32'h0);
    chk("rstbusy.stall", 32'(stallreq_o), 32'h0);
    aluop_i = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst_lw", 8'hE3, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 2, 5'd21, 32'h0,
           mk(1, 32'h0BAD_F00D, 1, 0, 3, 2, 32'h0000_0040, 4'b1111, 0, 32'h0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
